fft_bfly_ctrl: RTL and testbench

Sequencer for the in-place radix-2 complex FFT. It walks all stages of an N = 2^LOG_N point transform and issues one butterfly per cycle to the shared complex-float butterfly datapath (complex multiply plus complex add/sub). It generates the operand read addresses, the twiddle ROM index and the delayed write-back addresses/enable. It sits between the FFT top-level control and the coefficient RAM / butterfly pipeline.

---
 rtl/fft_pkg.sv | 12 +
 rtl/fft_wb_delay.sv | 26 ++
 rtl/fft_bfly_ctrl.sv | 147 ++++++++++++++
 tb/tb_fft_bfly_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and default sizing for the radix-2 FFT control slice.
package fft_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} fft_state_e;

   localparam int DEF_LOG_N     = 8;
   localparam int DEF_BFLY_LAT  = 4;
   localparam int DEF_ADDR_W    = DEF_LOG_N;
   localparam int DEF_TW_W      = DEF_LOG_N - 1;
   localparam int DEF_STAGE_W   = $clog2(DEF_LOG_N);

endpackage

// File: rtl/fft_wb_delay.sv
// Fixed-depth shift register that carries the read strobe/addresses forward
// to the cycle in which the butterfly result is ready for write-back.
module fft_wb_delay #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] wb_p [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) wb_p[i] <= '0;
      end else begin
         wb_p[0] <= din;
         for (int i = 1; i < DEPTH; i++) wb_p[i] <= wb_p[i-1];
      end
   end

   assign dout = wb_p[DEPTH-1];

endmodule

// File: rtl/fft_bfly_ctrl.sv
// Radix-2 in-place FFT sequencer: walks every stage, issues one operand pair
// per cycle with its twiddle index, and emits the delayed write-back strobe.
module fft_bfly_ctrl
   import fft_pkg::*;
#(
   parameter int LOG_N    = DEF_LOG_N,
   parameter int BFLY_LAT = DEF_BFLY_LAT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     inverse,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(LOG_N)-1:0] stage,
   output logic                     rd_en,
   output logic [LOG_N-1:0]         rd_addr_a,
   output logic [LOG_N-1:0]         rd_addr_b,
   output logic [LOG_N-2:0]         tw_addr,
   output logic                     wr_en,
   output logic [LOG_N-1:0]         wr_addr_a,
   output logic [LOG_N-1:0]         wr_addr_b
);

   localparam int ADDR_W  = LOG_N;
   localparam int TW_W    = LOG_N - 1;
   localparam int K_W     = LOG_N - 1;
   localparam int STAGE_W = $clog2(LOG_N);
   localparam int DRN_W   = $clog2(BFLY_LAT + 1);
   localparam int N_HALF  = 1 << (LOG_N - 1);

   fft_state_e         state_q, state_d;
   logic [STAGE_W-1:0] stage_q, stage_d;
   logic [K_W-1:0]     k_q, k_d;
   logic [DRN_W-1:0]   drn_q, drn_d;
   logic               inv_q, inv_d;

   logic [STAGE_W-1:0] lspan, shift;
   logic [ADDR_W-1:0]  span, k_ext, j_idx, grp, addr_a_d, addr_b_d;
   logic [TW_W-1:0]    tw_d;
   logic               issue_d;

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      k_d     = k_q;
      drn_d   = drn_q;
      inv_d   = inv_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ISSUE;
               inv_d   = inverse;
               stage_d = '0;
               k_d     = '0;
            end
         end
         ISSUE: begin
            if (k_q == K_W'(N_HALF - 1)) begin
               state_d = DRAIN;
               drn_d   = '0;
            end else begin
               k_d = k_q + K_W'(1);
            end
         end
         // Hold off the next stage until the last result of this one has been written.
         DRAIN: begin
            if (drn_q == DRN_W'(BFLY_LAT)) begin
               if (stage_q == STAGE_W'(LOG_N - 1)) begin
                  state_d = DONE;
               end else begin
                  state_d = ISSUE;
                  stage_d = stage_q + STAGE_W'(1);
                  k_d     = '0;
               end
            end else begin
               drn_d = drn_q + DRN_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            stage_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Addresses are built from the next-cycle stage/k so the registered outputs align with rd_en.
   always_comb begin
      if (inv_d) begin
         lspan = stage_d;
         shift = STAGE_W'(LOG_N - 1) - stage_d;
      end else begin
         lspan = STAGE_W'(LOG_N - 1) - stage_d;
         shift = stage_d;
      end
      span     = ADDR_W'(1) << lspan;
      k_ext    = ADDR_W'(k_d);
      j_idx    = k_ext & (span - ADDR_W'(1));
      grp      = k_ext >> lspan;
      addr_a_d = ((grp << lspan) << 1) | j_idx;
      addr_b_d = addr_a_d + span;
      tw_d     = TW_W'(j_idx) << shift;
      issue_d  = (state_d == ISSUE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         stage_q   <= '0;
         k_q       <= '0;
         drn_q     <= '0;
         inv_q     <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         tw_addr   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         stage_q   <= stage_d;
         k_q       <= k_d;
         drn_q     <= drn_d;
         inv_q     <= inv_d;
         rd_en     <= issue_d;
         rd_addr_a <= issue_d ? addr_a_d : '0;
         rd_addr_b <= issue_d ? addr_b_d : '0;
         tw_addr   <= issue_d ? tw_d : '0;
         busy      <= (state_d == ISSUE) || (state_d == DRAIN);
         done      <= (state_d == DONE);
      end
   end

   assign stage = stage_q;

   fft_wb_delay #(
      .WIDTH (1 + 2 * ADDR_W),
      .DEPTH (1 + BFLY_LAT)
   ) u_wb_delay (
      .clk  (clk),
      .rst  (rst),
      .din  ({rd_en, rd_addr_a, rd_addr_b}),
      .dout ({wr_en, wr_addr_a, wr_addr_b})
   );

endmodule

// File: tb/tb_fft_bfly_ctrl.sv
// Scoreboard bench for fft_bfly_ctrl: a small (N=8) and a default (N=256) instance
// driven with randomized transforms, checked against a loop-based schedule model.
module tb_fft_bfly_ctrl;

   localparam int BL = 4;
   localparam int LS = 3;
   localparam int LD = 8;

   typedef struct packed {
      int unsigned inst;
      int unsigned kind;
      int unsigned cyc;
      int unsigned st;
      int unsigned a;
      int unsigned b;
      int unsigned tw;
   } ev_t;

   logic clk, rst;
   logic start_s, inv_s, start_d, inv_d;

   logic       s_busy, s_done, s_rd, s_wr;
   logic [1:0] s_st, s_tw;
   logic [2:0] s_ra, s_rb, s_wa, s_wb;
   logic       d_busy, d_done, d_rd, d_wr;
   logic [2:0] d_st;
   logic [6:0] d_tw;
   logic [7:0] d_ra, d_rb, d_wa, d_wb;

   int unsigned cyc = 0;
   int unsigned n_chk = 0;
   int unsigned n_fail = 0;
   int unsigned rd_cnt_d = 0;
   int unsigned busy_from[2];
   int unsigned busy_to[2];
   ev_t exp_q[$];

   fft_bfly_ctrl #(.LOG_N(LS), .BFLY_LAT(BL)) u_small (
      .clk(clk), .rst(rst), .start(start_s), .inverse(inv_s),
      .busy(s_busy), .done(s_done), .stage(s_st),
      .rd_en(s_rd), .rd_addr_a(s_ra), .rd_addr_b(s_rb), .tw_addr(s_tw),
      .wr_en(s_wr), .wr_addr_a(s_wa), .wr_addr_b(s_wb)
   );

   fft_bfly_ctrl #(.LOG_N(LD), .BFLY_LAT(BL)) u_dflt (
      .clk(clk), .rst(rst), .start(start_d), .inverse(inv_d),
      .busy(d_busy), .done(d_done), .stage(d_st),
      .rd_en(d_rd), .rd_addr_a(d_ra), .rd_addr_b(d_rb), .tw_addr(d_tw),
      .wr_en(d_wr), .wr_addr_a(d_wa), .wr_addr_b(d_wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (cyc > 20000) begin
         $display("FAIL watchdog: cycle %0d exceeded budget 20000", cyc);
         $fatal(1, "watchdog expired");
      end
   end

   // Reference schedule: enumerate groups and butterflies stage by stage.
   task automatic push_xform(input int i, input int ln, input int unsigned t0, input bit inv);
      int n, half, p, span, sh;
      int unsigned c;
      ev_t e;
      n = 1 << ln;
      half = n / 2;
      p = half + 1 + BL;
      for (int s = 0; s < ln; s++) begin
         span = inv ? (1 << s) : (n >> (s + 1));
         sh   = inv ? (ln - 1 - s) : s;
         c    = t0 + 1 + s * p;
         for (int g = 0; g < half / span; g++) begin
            for (int j = 0; j < span; j++) begin
               e.inst = i; e.kind = 0; e.cyc = c; e.st = s;
               e.a = 2 * g * span + j; e.b = e.a + span; e.tw = (j << sh) % half;
               exp_q.push_back(e);
               e.kind = 1; e.cyc = c + 1 + BL; e.st = 0; e.tw = 0;
               exp_q.push_back(e);
               c++;
            end
         end
      end
      e.inst = i; e.kind = 2; e.cyc = t0 + ln * p + 1; e.st = 0; e.a = 0; e.b = 0; e.tw = 0;
      exp_q.push_back(e);
      busy_from[i] = t0 + 1;
      busy_to[i]   = t0 + ln * p;
   endtask

   always @(negedge clk) begin : monitor
      bit          rd_v[2], wr_v[2], dn_v[2], bz_v[2], en, bexp;
      int unsigned st_v[2], ra_v[2], rb_v[2], tw_v[2], wa_v[2], wb_v[2];
      int          idx[$];
      ev_t         e, act;
      rd_v[0] = s_rd; wr_v[0] = s_wr; dn_v[0] = s_done; bz_v[0] = s_busy;
      st_v[0] = 32'(s_st); ra_v[0] = 32'(s_ra); rb_v[0] = 32'(s_rb); tw_v[0] = 32'(s_tw);
      wa_v[0] = 32'(s_wa); wb_v[0] = 32'(s_wb);
      rd_v[1] = d_rd; wr_v[1] = d_wr; dn_v[1] = d_done; bz_v[1] = d_busy;
      st_v[1] = 32'(d_st); ra_v[1] = 32'(d_ra); rb_v[1] = 32'(d_rb); tw_v[1] = 32'(d_tw);
      wa_v[1] = 32'(d_wa); wb_v[1] = 32'(d_wb);
      if (d_rd) rd_cnt_d = rd_cnt_d + 1;
      for (int i = 0; i < 2; i++) begin
         bexp = (cyc >= busy_from[i]) && (cyc <= busy_to[i]);
         n_chk++;
         if (bz_v[i] !== bexp) begin
            n_fail++;
            $display("FAIL busy inst%0d cycle %0d: got %0b want %0b", i, cyc, bz_v[i], bexp);
         end
         for (int k = 0; k < 3; k++) begin
            en = (k == 0) ? rd_v[i] : (k == 1) ? wr_v[i] : dn_v[i];
            if (en) begin
               act.inst = i; act.kind = k; act.cyc = cyc;
               act.st = (k == 0) ? st_v[i] : 0;
               act.a  = (k == 0) ? ra_v[i] : (k == 1) ? wa_v[i] : 0;
               act.b  = (k == 0) ? rb_v[i] : (k == 1) ? wb_v[i] : 0;
               act.tw = (k == 0) ? tw_v[i] : 0;
               idx = exp_q.find_first_index(x) with (x.inst == i && x.kind == k);
               n_chk++;
               if (idx.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected inst%0d kind%0d at cycle %0d a=%0d b=%0d", i, k, cyc, act.a, act.b);
               end else begin
                  e = exp_q[idx[0]];
                  exp_q.delete(idx[0]);
                  if (act != e) begin
                     n_fail++;
                     $display("FAIL event inst%0d kind%0d: got cyc=%0d st=%0d a=%0d b=%0d tw=%0d want cyc=%0d st=%0d a=%0d b=%0d tw=%0d",
                              i, k, act.cyc, act.st, act.a, act.b, act.tw, e.cyc, e.st, e.a, e.b, e.tw);
                  end
               end
            end
         end
         idx = exp_q.find_first_index(x) with (x.inst == i && x.cyc < cyc);
         if (idx.size() != 0) begin
            e = exp_q[idx[0]];
            exp_q.delete(idx[0]);
            n_chk++;
            n_fail++;
            $display("FAIL missed inst%0d kind%0d: got no strobe, want cyc=%0d a=%0d b=%0d", i, e.kind, e.cyc, e.a, e.b);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_until(input int unsigned c);
      while (cyc < c) step();
   endtask

   task automatic go(input int i, input bit inv, output int unsigned t0);
      t0 = cyc;
      if (i == 0) begin start_s = 1'b1; inv_s = inv; end
      else begin start_d = 1'b1; inv_d = inv; rd_cnt_d = 0; end
      push_xform(i, (i == 0) ? LS : LD, t0, inv);
      step();
      if (i == 0) begin start_s = 1'b0; inv_s = 1'($urandom); end
      else begin start_d = 1'b0; inv_d = 1'($urandom); end
   endtask

   task automatic spurious(input int i);
      if (i == 0) begin start_s = 1'b1; inv_s = ~inv_s; end
      else begin start_d = 1'b1; inv_d = 1'b1; end
      step();
      if (i == 0) start_s = 1'b0; else start_d = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      n_chk++;
      if ({s_rd, s_ra, s_rb, s_tw, s_wr, s_wa, s_wb, s_busy, s_done, s_st} !== '0) begin
         n_fail++;
         $display("FAIL %s small outputs: got %b want all zero", tag,
                  {s_rd, s_ra, s_rb, s_tw, s_wr, s_wa, s_wb, s_busy, s_done, s_st});
      end
      n_chk++;
      if ({d_rd, d_ra, d_rb, d_tw, d_wr, d_wa, d_wb, d_busy, d_done, d_st} !== '0) begin
         n_fail++;
         $display("FAIL %s default outputs: got %b want all zero", tag,
                  {d_rd, d_ra, d_rb, d_tw, d_wr, d_wa, d_wb, d_busy, d_done, d_st});
      end
   endtask

   task automatic stim_small();
      int unsigned t0;
      go(0, 1'b0, t0);
      wait_until(t0 + 29);
      go(0, 1'b1, t0);
      wait_until(t0 + 29);
      repeat (25) begin
         repeat ($urandom_range(0, 3)) step();
         go(0, 1'($urandom), t0);
         if ($urandom_range(0, 1) == 1) begin
            wait_until(t0 + $urandom_range(1, 28));
            spurious(0);
         end
         wait_until(t0 + 29);
      end
   endtask

   task automatic stim_big();
      int unsigned t0;
      go(1, 1'b0, t0);
      wait_until(t0 + 50);
      spurious(1);
      wait_until(t0 + 1066);
      n_chk++;
      if (rd_cnt_d != 1024) begin
         n_fail++;
         $display("FAIL rd_count default: got %0d want 1024", rd_cnt_d);
      end
      go(1, 1'($urandom), t0);
      wait_until(t0 + 1066);
   endtask

   initial begin : stim
      int unsigned t0;
      rst = 1'b1; start_s = 1'b0; inv_s = 1'b0; start_d = 1'b0; inv_d = 1'b0;
      busy_from[0] = 1; busy_to[0] = 0; busy_from[1] = 1; busy_to[1] = 0;
      repeat (3) step();
      check_zero("reset");
      rst = 1'b0;
      step();
      fork
         stim_small();
         stim_big();
      join
      repeat (3) step();
      go(0, 1'b0, t0);
      wait_until(t0 + 15);
      rst = 1'b1;
      exp_q.delete();
      busy_from[0] = 1; busy_to[0] = 0;
      #1;
      check_zero("midreset");
      repeat (3) step();
      rst = 1'b0;
      repeat (10) step();
      go(0, 1'b0, t0);
      wait_until(t0 + 35);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL leftover events: got %0d pending want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
